// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral holding NUM_REGS control registers with serial read-back.
// Serial pins are synchronised to clk; registers change only when a frame is committed.
module spi_reg_bank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err,
    output logic                         busy
);
    // state  | meaning
    // IDLE   | waiting for ncs falling edge
    // SHIFT  | capturing frame bits on sclk rising edges
    // HOLD   | full frame captured; any extra sclk rise marks overrun
    // COMMIT | one cycle: write register or flag frame error

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, COMMIT} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sr, ncs_sr, copi_sr;
    logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, copi_bit;

    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_shift;
    logic               overrun;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-1:0]  regs [NUM_REGS];
    logic [DATA_W-1:0]  rd_word;

    logic               rx_rw, hdr_rw, frame_ok;
    logic [ADDR_W-1:0]  rx_addr, hdr_addr;
    logic [DATA_W-1:0]  rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr <= '0;
            ncs_sr  <= '1;
            copi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            ncs_sr  <= {ncs_sr[SYNC_STAGES-2:0], ncs};
            copi_sr <= {copi_sr[SYNC_STAGES-2:0], copi};
        end
    end

    assign sclk_rise = sclk_sr[SYNC_STAGES-2] & ~sclk_sr[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_sr[SYNC_STAGES-2] & sclk_sr[SYNC_STAGES-1];
    assign ncs_rise  = ncs_sr[SYNC_STAGES-2] & ~ncs_sr[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_sr[SYNC_STAGES-2] & ncs_sr[SYNC_STAGES-1];
    // copi is quasi-static around sclk edges, so the fully synced stage is safe to sample
    assign copi_bit  = copi_sr[SYNC_STAGES-1];

    assign rx_rw    = rx_shift[FRAME_W-1];
    assign rx_addr  = rx_shift[DATA_W +: ADDR_W];
    assign rx_data  = rx_shift[DATA_W-1:0];
    // header sits in the low bits once exactly 1+ADDR_W bits have been shifted in
    assign hdr_rw   = rx_shift[ADDR_W];
    assign hdr_addr = rx_shift[ADDR_W-1:0];
    assign frame_ok = (bit_cnt == CNT_W'(FRAME_W)) && !overrun;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(hdr_addr) == k) rd_word = regs[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ncs_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (ncs_rise)
                    state_nxt = COMMIT;
                else if (sclk_rise && bit_cnt == CNT_W'(FRAME_W - 1))
                    state_nxt = HOLD;
            end
            HOLD:    if (ncs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            overrun   <= 1'b0;
            tx_shift  <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        overrun  <= 1'b0;
                        tx_shift <= '0;
                    end
                end
                SHIFT, HOLD: begin
                    if (sclk_rise) begin
                        if (state == SHIFT) begin
                            rx_shift <= {rx_shift[FRAME_W-2:0], copi_bit};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (bit_cnt == CNT_W'(1 + ADDR_W) && !hdr_rw)
                            tx_shift <= rd_word;
                        else if (bit_cnt > CNT_W'(1 + ADDR_W))
                            tx_shift <= tx_shift << 1;
                    end
                end
                COMMIT: begin
                    tx_shift <= '0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (rx_rw) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (int'(rx_addr) == k) begin
                                regs[k]      <= rx_data;
                                wr_strobe[k] <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs[k];
    end

    assign cipo    = (state != IDLE) & tx_shift[DATA_W-1];
    assign cipo_oe = ~ncs_sr[SYNC_STAGES-1];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: SPI frames driven from one initial block,
// strobe and read-back expectations checked through scoreboard queues.
module tb_spi_reg_bank;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int NUM_REGS = 5;
    localparam int HALF = 8;   // clk periods per sclk phase

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic ncs = 1'b1;
    logic copi = 1'b0;
    logic cipo, cipo_oe, frame_err, busy;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0] wr_strobe;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int exp_err = 0;
    logic [DATA_W-1:0] mdl [NUM_REGS];
    logic cipo_q [$];
    logic [NUM_REGS-1:0] strobe_q [$];
    logic [NUM_REGS-1:0] prev_strobe = '0;

    spi_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse monitor: strobes are popped from the scoreboard, errors counted
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe != '0) begin
                check("strobe_width", 64'(prev_strobe), 64'(0));
                if (strobe_q.size() == 0) begin
                    check("strobe_unexpected", 64'(wr_strobe), 64'(0));
                end else begin
                    logic [NUM_REGS-1:0] e;
                    e = strobe_q.pop_front();
                    check("strobe_value", 64'(wr_strobe), 64'(e));
                    check("regs_at_strobe", 64'(regs_flat), mdl_flat());
                end
            end
            if (frame_err) err_cnt++;
            prev_strobe = wr_strobe;
        end else begin
            prev_strobe = '0;
        end
    end

    function automatic logic [63:0] mdl_flat();
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = mdl[k];
        return f;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        wait_clk(HALF);
        check("cipo_oe_active", 64'(cipo_oe), 64'(1));
        check("busy_active", 64'(busy), 64'(1));
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        ncs = 1'b1;
        wait_clk(10);
        check("cipo_oe_idle", 64'(cipo_oe), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    // drive n bits: frame MSB-first, then 'extra' for any bits past 16
    task automatic send_bits(input logic [15:0] frame, input int n, input logic extra);
        logic rw;
        int addr;
        logic [DATA_W-1:0] rv;
        logic b;
        rw = frame[15];
        addr = int'(frame[14:8]);
        rv = (!rw && addr < NUM_REGS) ? mdl[addr] : '0;
        for (int i = 8; i < 16 && i < n; i++) cipo_q.push_back(rv[15 - i]);
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? frame[15 - i] : extra;
            copi = b;
            wait_clk(HALF);
            if (i >= 8 && i < 16) begin
                logic e;
                e = cipo_q.pop_front();
                check("cipo_bit", 64'(cipo), 64'(e));
            end
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        copi = 1'b0;
    endtask

    task automatic frame_check(input string tag);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_strobe_q_empty"}, 64'(strobe_q.size()), 64'(0));
        check({tag, "_regs"}, 64'(regs_flat), mdl_flat());
    endtask

    initial begin
        for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
        wait_clk(5);
        check("rst_regs", 64'(regs_flat), 64'(0));
        check("rst_cipo", 64'(cipo), 64'(0));
        check("rst_cipo_oe", 64'(cipo_oe), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_strobe", 64'(wr_strobe), 64'(0));
        check("rst_err", 64'(frame_err), 64'(0));
        rst = 1'b0;
        wait_clk(5);
        check("post_rst_busy", 64'(busy), 64'(0));

        // 1: write reg0
        mdl[0] = 8'h55;
        strobe_q.push_back(5'b00001);
        cs_low(); send_bits(16'h8055, 16, 1'b0); cs_high();
        frame_check("t1");

        // 2: write reg4 then read it back
        mdl[4] = 8'hA5;
        strobe_q.push_back(5'b10000);
        cs_low(); send_bits(16'h84A5, 16, 1'b0); cs_high();
        frame_check("t2w");
        cs_low(); send_bits(16'h0400, 16, 1'b0); cs_high();
        frame_check("t2r");
        check("t2_cipo_q_empty", 64'(cipo_q.size()), 64'(0));

        // read of reg0 via a different pattern
        cs_low(); send_bits(16'h0000, 16, 1'b0); cs_high();
        frame_check("t2r0");

        // 3: short frame
        exp_err++;
        cs_low(); send_bits(16'h8177, 12, 1'b0); cs_high();
        frame_check("t3");

        // 4: overrun frame
        exp_err++;
        cs_low(); send_bits(16'h8133, 17, 1'b1); cs_high();
        frame_check("t4");

        // 5: out-of-range address write
        cs_low(); send_bits(16'hFF12, 16, 1'b0); cs_high();
        frame_check("t5");

        // 6: reset mid-frame, then a clean frame
        cs_low(); send_bits(16'h8266, 8, 1'b0);
        rst = 1'b1;
        ncs = 1'b1;
        wait_clk(5);
        for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
        check("t6_rst_regs", 64'(regs_flat), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        wait_clk(10);
        frame_check("t6a");
        mdl[2] = 8'h66;
        strobe_q.push_back(5'b00100);
        cs_low(); send_bits(16'h8266, 16, 1'b0); cs_high();
        frame_check("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
